// File: rtl/i2c_spi_pin_arbiter.sv
// Request/grant arbiter for the shared I2C_SCLK/I2C_SDAT pins between the
// G-sensor SPI master and the EEPROM I2C master, with parked-bus guard gaps.
module i2c_spi_pin_arbiter #(
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_req,
  output logic       spi_gnt,
  input  logic       spi_sclk,
  input  logic       spi_sdo,
  input  logic       spi_sdo_oe,
  input  logic       spi_cs_n,
  input  logic       i2c_req,
  output logic       i2c_gnt,
  input  logic       i2c_scl,
  input  logic       i2c_sda_oe,
  output logic       pin_sclk,
  output logic       pin_sdat_out,
  output logic       pin_sdat_oe,
  output logic       gsensor_cs_n,
  output logic [1:0] owner,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SPI   = 2'b01,
    S_I2C   = 2'b10,
    S_GUARD = 2'b11
  } state_t;

  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT_CYCLES);
  localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] hold_q, hold_d, hold_inc;
  logic        last_i2c_q, last_i2c_d;
  logic        spi_mask_q, spi_mask_d;
  logic        i2c_mask_q, i2c_mask_d;
  logic        tout_q, tout_d;
  logic        sclk_q, sclk_d;
  logic        sdat_q, sdat_d;
  logic        oe_q, oe_d;
  logic        cs_n_q, cs_n_d;
  logic        spi_eff, i2c_eff, hold_expired;

  assign spi_eff      = spi_req & ~spi_mask_q;
  assign i2c_eff      = i2c_req & ~i2c_mask_q;
  assign hold_inc     = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
  assign hold_expired = TIMEOUT_EN && (hold_inc == TIMEOUT_L);

  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    hold_d      = hold_q;
    last_i2c_d  = last_i2c_q;
    // A revoke mask lasts until its requester has been seen low once.
    spi_mask_d  = spi_mask_q & spi_req;
    i2c_mask_d  = i2c_mask_q & i2c_req;
    tout_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spi_eff && (!i2c_eff || last_i2c_q)) begin
          state_d    = S_SPI;
          hold_d     = 16'd0;
          last_i2c_d = 1'b0;
        end else if (i2c_eff) begin
          state_d    = S_I2C;
          hold_d     = 16'd0;
          last_i2c_d = 1'b1;
        end
      end
      S_SPI: begin
        hold_d = hold_inc;
        // The SPI master keeps the bus until its frame ends (cs_n high).
        if (!spi_req && spi_cs_n) begin
          state_d     = S_GUARD;
          guard_cnt_d = GUARD_LAST;
        end else if (hold_expired) begin
          state_d     = S_GUARD;
          guard_cnt_d = GUARD_LAST;
          tout_d      = 1'b1;
          spi_mask_d  = 1'b1;
        end
      end
      S_I2C: begin
        hold_d = hold_inc;
        if (!i2c_req) begin
          state_d     = S_GUARD;
          guard_cnt_d = GUARD_LAST;
        end else if (hold_expired) begin
          state_d     = S_GUARD;
          guard_cnt_d = GUARD_LAST;
          tout_d      = 1'b1;
          i2c_mask_d  = 1'b1;
        end
      end
      default: begin
        if (guard_cnt_q == 8'd0) state_d = S_IDLE;
        else                     guard_cnt_d = guard_cnt_q - 8'd1;
      end
    endcase
  end

  // Pins follow the next state so a revoke or release parks on the same edge.
  always_comb begin
    sclk_d = 1'b1;
    sdat_d = 1'b1;
    oe_d   = 1'b0;
    cs_n_d = 1'b1;
    case (state_d)
      S_SPI: begin
        sclk_d = spi_sclk;
        sdat_d = spi_sdo;
        oe_d   = spi_sdo_oe;
        cs_n_d = spi_cs_n;
      end
      S_I2C: begin
        sclk_d = i2c_scl;
        sdat_d = 1'b0;
        oe_d   = i2c_sda_oe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      guard_cnt_q <= 8'd0;
      hold_q      <= 16'd0;
      last_i2c_q  <= 1'b1;
      spi_mask_q  <= 1'b0;
      i2c_mask_q  <= 1'b0;
      tout_q      <= 1'b0;
      sclk_q      <= 1'b1;
      sdat_q      <= 1'b1;
      oe_q        <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      hold_q      <= hold_d;
      last_i2c_q  <= last_i2c_d;
      spi_mask_q  <= spi_mask_d;
      i2c_mask_q  <= i2c_mask_d;
      tout_q      <= tout_d;
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      oe_q        <= oe_d;
      cs_n_q      <= cs_n_d;
    end
  end

  assign spi_gnt      = (state_q == S_SPI);
  assign i2c_gnt      = (state_q == S_I2C);
  assign owner        = state_q;
  assign timeout_err  = tout_q;
  assign pin_sclk     = sclk_q;
  assign pin_sdat_out = sdat_q;
  assign pin_sdat_oe  = oe_q;
  assign gsensor_cs_n = cs_n_q;

endmodule
